// File: rtl/l2_request_scheduler.sv
// L2 request scheduler: fill-priority arbiter with round-robin cores and 1-cycle registered grant.
// Optional starvation guard enabled by macro L2_SCHED_STARVE_GUARD_EN.
module l2_request_scheduler #(
    parameter int NUM_REQUESTERS = 4,
    parameter int REQ_WIDTH      = 128,
    parameter int FILL_BURST_MAX = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQUESTERS-1:0]           req_valid,
    input  logic [NUM_REQUESTERS*REQ_WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]           req_ready,
    input  logic                                fill_valid,
    input  logic [REQ_WIDTH-1:0]                fill_data,
    output logic                                fill_ready,
    input  logic                                stall,
    output logic                                grant_valid,
    output logic [REQ_WIDTH-1:0]                grant_data,
    output logic                                grant_is_fill,
    output logic [$clog2(NUM_REQUESTERS)-1:0]   grant_id,
    output logic                                perf_starve_boost
);
    localparam int IW = $clog2(NUM_REQUESTERS);

    logic [IW-1:0]        rr_ptr_q;
    logic [IW-1:0]        rr_nxt;
    logic [IW-1:0]        sel_idx;
    logic                 sel_found;
    logic                 any_req;
    logic                 core_en;
    logic                 fill_acc;
    logic                 core_acc;
    logic                 boost_act;
    logic                 boost_fire;
    logic [REQ_WIDTH-1:0] core_pay;

    logic                 gv_q;
    logic [REQ_WIDTH-1:0] gdata_q;
    logic                 gfill_q;
    logic [IW-1:0]        gid_q;
    logic                 perf_q;

    assign any_req = |req_valid;

    // Round-robin search starting at rr_ptr_q, wrapping past the last core
    always_comb begin
        int c;
        c         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int o = 0; o < NUM_REQUESTERS; o++) begin
            c = int'(rr_ptr_q) + o;
            if (c >= NUM_REQUESTERS) c = c - NUM_REQUESTERS;
            if (!sel_found && req_valid[c]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(c);
            end
        end
    end

    assign rr_nxt = (int'(sel_idx) == NUM_REQUESTERS - 1) ? '0 : sel_idx + IW'(1);
    assign core_pay = req_data[int'(sel_idx)*REQ_WIDTH +: REQ_WIDTH];

    assign fill_ready = reset & ~stall & fill_valid & ~boost_act;
    assign core_en    = reset & ~stall & (~fill_valid | boost_act);

    always_comb begin
        req_ready = '0;
        if (core_en && sel_found) req_ready[sel_idx] = 1'b1;
    end

    assign fill_acc = fill_ready;
    assign core_acc = |(req_valid & req_ready);

`ifdef L2_SCHED_STARVE_GUARD_EN
    typedef enum logic {FILL_PRIO, CORE_BOOST} state_t;

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       boost_cond;

    assign boost_cond = (run_q >= 4'(FILL_BURST_MAX)) && any_req;
    assign boost_act  = ((state_q == CORE_BOOST) || boost_cond) && any_req;
    assign boost_fire = core_acc & boost_act;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (fill_acc) begin
            if (!any_req)           run_d = '0;
            else if (run_q != 4'hF) run_d = run_q + 4'd1;
        end else if (core_acc) begin
            run_d = '0;
        end
        unique case (state_q)
            FILL_PRIO: begin
                if (fill_acc && any_req && run_d >= 4'(FILL_BURST_MAX))
                    state_d = CORE_BOOST;
            end
            CORE_BOOST: begin
                if (core_acc) state_d = FILL_PRIO;
            end
            default: state_d = FILL_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL_PRIO;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end
`else
    assign boost_act  = 1'b0;
    assign boost_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gv_q     <= 1'b0;
            gdata_q  <= '0;
            gfill_q  <= 1'b0;
            gid_q    <= '0;
            perf_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            perf_q <= boost_fire;
            if (!stall) begin
                gv_q <= fill_acc | core_acc;
                if (fill_acc) begin
                    gdata_q <= fill_data;
                    gfill_q <= 1'b1;
                    gid_q   <= '0;
                end else if (core_acc) begin
                    gdata_q  <= core_pay;
                    gfill_q  <= 1'b0;
                    gid_q    <= sel_idx;
                    rr_ptr_q <= rr_nxt;
                end
            end
        end
    end

    assign grant_valid       = gv_q;
    assign grant_data        = gdata_q;
    assign grant_is_fill     = gfill_q;
    assign grant_id          = gid_q;
    assign perf_starve_boost = perf_q;

endmodule

// File: doc/l2_request_scheduler.md
L2_REQUEST_SCHEDULER -- requirements
Module: l2_request_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQUESTERS, 4, number of core request ports.
- REQ_WIDTH, 128, request payload bits.
- FILL_BURST_MAX, 3, consecutive fill grants allowed while a core waits; range 1..15.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQUESTERS  per-core request present.
- req_data  in  NUM_REQUESTERS*REQ_WIDTH  per-core payload; core i at bits [i*REQ_WIDTH +: REQ_WIDTH].
- req_ready  out  NUM_REQUESTERS  per-core accept strobe, combinational.
- fill_valid  in  1  restarted request after memory fill.
- fill_data  in  REQ_WIDTH  restarted payload.
- fill_ready  out  1  fill accept strobe, combinational.
- stall  in  1  downstream pipeline backpressure.
- grant_valid  out  1  registered grant present.
- grant_data  out  REQ_WIDTH  granted payload.
- grant_is_fill  out  1  grant came from the fill port.
- grant_id  out  $clog2(NUM_REQUESTERS)  source core; 0 when grant_is_fill=1.
- perf_starve_boost  out  1  one-cycle pulse when the starvation guard forces a core grant.

Function
REQ-003 The block SHALL have no more than one source accepted per cycle, and SHALL accept only when stall=0.
REQ-004 A source SHALL be accepted when its valid and its ready are both 1 in the same cycle; each ready SHALL be 0 when stall=1.
REQ-005 Latency SHALL be 1 cycle: a payload accepted in cycle N appears on grant_* in cycle N+1.
REQ-006 With stall=0 and no source accepted, grant_valid SHALL be 0 in the next cycle.
REQ-007 With stall=1, all grant_* outputs SHALL hold their values and no source state SHALL change.
REQ-008 The fill port SHALL have priority over cores, except as described in REQ-011.
REQ-009 Among cores, selection SHALL be round-robin. The search starts at rr_ptr and wraps from NUM_REQUESTERS-1 to 0.
REQ-010 After a core k grant, rr_ptr SHALL become (k+1) mod NUM_REQUESTERS. rr_ptr SHALL NOT change on fill grants or idle cycles.
REQ-011 Starvation guard, 4-bit fill_run counter:
- It SHALL increment on each fill grant made while any req_valid=1.
- It SHALL clear on any core grant.
- It SHALL clear on a fill grant made with no req_valid set.
- It SHALL saturate at 15.
- When fill_run>=FILL_BURST_MAX and any req_valid=1, the next accept SHALL go to the round-robin core, fill_ready SHALL be 0, and perf_starve_boost SHALL pulse.
REQ-012 The guard state machine SHALL have two states:
- FILL_PRIO: normal operation.
- CORE_BOOST: entered when the REQ-011 condition holds; exited to FILL_PRIO after exactly one core accept.
- A stall SHALL hold the current state.
REQ-013 If a source drops valid before acceptance, it SHALL lose its turn. No payload SHALL be captured.

Reset
REQ-014 While reset=0, outputs and state SHALL take these values immediately, independent of clk:
- grant_valid=0, grant_data=0, grant_is_fill=0, grant_id=0.
- perf_starve_boost=0, rr_ptr=0, fill_run=0, state FILL_PRIO.
REQ-015 A reset asserted mid-stall SHALL discard the held grant. The first accept after deassertion SHALL be evaluated on the first rising edge with reset=1.
REQ-016 Every ready output SHALL be 0 while reset=0.

Configuration
REQ-017 Macro L2_SCHED_STARVE_GUARD_EN:
- Defined: REQ-011 and REQ-012 apply.
- Undefined: the fill port always wins, fill_run and CORE_BOOST are omitted, and perf_starve_boost is tied to 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Round-robin: req_valid=4'b1111, fill_valid=0, stall=0 for 8 cycles -> grant_id 0,1,2,3,0,1,2,3 on consecutive cycles.
- Fill priority: req_valid=4'b0100 and fill_valid=1 in the same cycle, FILL_BURST_MAX=3, guard macro defined -> first grant has grant_is_fill=1.
- Starvation guard: fill_valid=1 held with req_valid=4'b0010, guard macro defined -> fills granted 3 times; 4th grant is grant_id=1 with perf_starve_boost=1; 5th grant is a fill. Guard macro undefined -> fills every cycle and grant_id=1 is never granted.
- Stall hold: grant of core 2 payload 0xA5 outstanding, then stall=1 for 5 cycles with all valids high -> grant_data stays 0xA5 and all readys=0; after release the next grant is core 3.
- Reset mid-operation: reset=0 during stall with grant_valid=1 -> grant_valid=0 before the next clk edge; after release, req_valid=4'b1000 -> grant_id=3 and rr_ptr becomes 0.
- Wrap and drop: rr_ptr=3, req_valid=4'b1001 -> grant 3, then grant 0. Core 0 dropping valid while core 3 is granted -> no core 0 grant.
